uart_rx_core: RTL and testbench
===============================

# uart_rx_core

UART receive front end combining a programmable 16x-oversampling baud tick generator with an 8N1 serial receiver. It sits between the asynchronous `rx` pin and the byte-level consumer logic. It recovers one data byte per frame, LSB first, and flags completion with a single-cycle strobe.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz, used for divisor calculation.
- `DATA_WIDTH`, default 8: data bits per frame.
- `clk`  in  1: system clock, rising-edge active.
- `arst`  in  1: reset, asynchronous and active-high. Clears all state immediately.
- `baud_sel`  in  4: baud rate select.
- `rx`  in  1: serial input; asynchronous to `clk`; idles high.
- `data_out`  out  DATA_WIDTH: last correctly framed byte.
- `rx_done`  out  1: one-cycle strobe indicating `data_out` was just updated.
- `frame_err`  out  1: one-cycle strobe indicating the stop bit was sampled low.
- `rx_busy`  out  1: high while a frame is in progress. This is the internal generator enable.

## Operation
- **Baud select.** The tick divisor is `CLK_FREQ / (16*baud)`, using integer floor.
  - 0 = 1200 (5208), 1 = 2400 (2604), 2 = 4800 (1302), 3 = 9600 (651).
  - 4 = 19200 (325), 5 = 38400 (162), 6 = 57600 (108), 7 = 115200 (54).
  - 8–15 = 9600 (651).
- **Tick generator.**
  - While enable is low, the counter is held at 0 and `tick` is 0.
  - While enable is high, the counter increments every clock.
  - When the counter is at or above divisor−1, it wraps to 0 and `tick` pulses for exactly one cycle.
  - The divisor is read continuously, so a change to `baud_sel` mid-frame takes effect at the next compare. Changing `baud_sel` mid-frame is unsupported and the frame content is undefined.
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer, reset to 1. All FSM decisions use the synchronized value `rx_s`.
- **Receiver FSM.** States are IDLE, START, DATA and STOP. It keeps a tick counter (0–15), a bit counter (0–DATA_WIDTH−1) and a shift register.
  - **IDLE:** enable = 0. When `rx_s` = 0, go to START and clear both counters.
  - **START:** on the 8th tick (mid start bit), if `rx_s` = 0, go to DATA with counters cleared. Otherwise treat it as a false start and return to IDLE with no outputs.
  - **DATA:** on each 16th tick, right-shift `rx_s` into the MSB of the shift register (LSB-first reception). After DATA_WIDTH bits, go to STOP.
  - **STOP:** on the 16th tick (mid stop bit):
    - If `rx_s` = 1, load `data_out` from the shift register, pulse `rx_done`, and go to IDLE.
    - If `rx_s` = 0, pulse `frame_err`, leave `data_out` unchanged, and go to IDLE.
- `rx_busy` = (state != IDLE). Returning to IDLE at mid stop bit allows a back-to-back start bit to be detected.
- **Reset values.** State IDLE, `data_out` = 0, `rx_done` = 0, `frame_err` = 0, `rx_busy` = 0, tick counter 0, synchronizer flops 1.

## Timing
- Start detection latency: the FSM leaves IDLE 3 clock edges after `rx` falls, covering 2 synchronizer stages and the state register.
- The generator counter starts from 0 on the first cycle of START. The first tick occurs divisor clocks later.
- Sampling points, counted in ticks after entering START:
  - start check at tick 8;
  - data bit n at tick 8 + 16(n+1);
  - stop bit at tick 8 + 16·(DATA_WIDTH+1), which is tick 152 for 8 bits.
- `rx_done` and `frame_err` are registered. They assert in the clock cycle after the sampling tick and are high for exactly 1 cycle.
- `data_out` changes in the same cycle `rx_done` rises and holds until the next good frame.
- At 9600 baud and 100 MHz, the stop sample is about 152·651 clocks (about 989.5 µs) after the start edge.
- **Reset mid-frame.** Everything returns to reset values immediately. No `rx_done` or `frame_err` is produced for the aborted frame.
- `rx` glitches in IDLE shorter than half a bit are rejected by the START check.

## Test plan
- **Reset.** Assert `arst` with `rx` = 1. Required: `data_out` = 0x00, `rx_done` = 0, `frame_err` = 0, `rx_busy` = 0, no ticks.
- **Nominal byte.** `baud_sel` = 3, `rx` held 1, then 0 for 100 µs, then bits 1,0,1,1,0,1 at 100 µs each, then `rx` held 1. Required: one `rx_done` pulse, `data_out` = 0xED, `frame_err` never asserted.
- **Exact timing.** `baud_sel` = 7. Send 0x55 at an exact 8680 ns bit period. Required:
  - tick spacing of 54 clocks;
  - `data_out` = 0x55;
  - `rx_done` 1 cycle wide and 152·54 + 3 ± 1 clocks after the falling edge.
- **False start.** At `baud_sel` = 3, drive a 2 µs low pulse on idle `rx`. Required: `rx_busy` rises then falls within 8 ticks, no `rx_done`, `data_out` unchanged.
- **Framing error.** Send 0xA3 with the stop bit low. Required: one-cycle `frame_err`, no `rx_done`, `data_out` keeps its previous value.
- **Back-to-back and reset mid-frame.** Send 0x12 and 0x34 with no idle gap. Required: two `rx_done` pulses, values 0x12 then 0x34. Then assert `arst` mid-data. Required: immediate return to reset values and no completion strobe.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receive front end: programmable 16x baud tick generator feeding an
// 8N1 receiver with a 2-flop input synchronizer.
module uart_rx_core #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [3:0]            baud_sel,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rx_done,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int CW = 24;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] DIV_1200   = CW'(CLK_FREQ / (16 * 1200));
    localparam logic [CW-1:0] DIV_2400   = CW'(CLK_FREQ / (16 * 2400));
    localparam logic [CW-1:0] DIV_4800   = CW'(CLK_FREQ / (16 * 4800));
    localparam logic [CW-1:0] DIV_9600   = CW'(CLK_FREQ / (16 * 9600));
    localparam logic [CW-1:0] DIV_19200  = CW'(CLK_FREQ / (16 * 19200));
    localparam logic [CW-1:0] DIV_38400  = CW'(CLK_FREQ / (16 * 38400));
    localparam logic [CW-1:0] DIV_57600  = CW'(CLK_FREQ / (16 * 57600));
    localparam logic [CW-1:0] DIV_115200 = CW'(CLK_FREQ / (16 * 115200));
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [CW-1:0]         div;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  en;
    logic                  tick;

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  rx_s;

    logic [1:0]            state_q, state_d;
    logic [3:0]            tcnt_q, tcnt_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;

    always_comb begin
        div = DIV_9600;
        case (baud_sel)
            4'd0:    div = DIV_1200;
            4'd1:    div = DIV_2400;
            4'd2:    div = DIV_4800;
            4'd3:    div = DIV_9600;
            4'd4:    div = DIV_19200;
            4'd5:    div = DIV_38400;
            4'd6:    div = DIV_57600;
            4'd7:    div = DIV_115200;
            default: div = DIV_9600;
        endcase
    end

    assign en = (state_q != S_IDLE);

    // Divisor is compared live, so a baud change lands at the next compare.
    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q >= div - CNT_ONE) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign sync1_d = rx;
    assign sync2_d = sync1_q;
    assign rx_s    = sync2_q;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                        if (bcnt_q == BW'(DATA_WIDTH - 1)) begin
                            bcnt_d  = '0;
                            state_d = S_STOP;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    // Leaving at mid stop bit leaves room for a back-to-back start.
                    if (tcnt_q == 4'd15) begin
                        state_d = S_IDLE;
                        if (rx_s) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q   <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = en;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are queued as driven and
// matched against rx_done / frame_err strobes by a negedge monitor.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int CLK_FREQ = 10_000_000;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [3:0] baud_sel = 4'd3;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  last_good = 8'h00;
    int unsigned cyc = 0;
    int unsigned done_cyc = 0;
    int unsigned fall_cyc = 0;

    uart_rx_core #(
        .CLK_FREQ(CLK_FREQ),
        .DATA_WIDTH(8)
    ) dut (
        .clk(clk),
        .arst(arst),
        .baud_sel(baud_sel),
        .rx(rx),
        .data_out(data_out),
        .rx_done(rx_done),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_div(input int sel);
        int b;
        case (sel)
            0:       b = 1200;
            1:       b = 2400;
            2:       b = 4800;
            3:       b = 9600;
            4:       b = 19200;
            5:       b = 38400;
            6:       b = 57600;
            7:       b = 115200;
            default: b = 9600;
        endcase
        return CLK_FREQ / (16 * b);
    endfunction

    task automatic drive(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int bclk);
        exp_t e;
        e.err  = ~stop;
        e.data = b;
        sb.push_back(e);
        fall_cyc = cyc;
        drive(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(b[i], bclk);
        drive(stop, bclk);
        rx = 1'b1;
    endtask

    task automatic drain(input string tag, input int bound);
        int k;
        k = 0;
        while ((sb.size() != 0 || rx_busy) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        chk({tag, "_idle"}, 32'(rx_busy), 32'd0);
    endtask

    initial begin
        logic dp;
        logic fp;
        exp_t e;
        dp = 1'b0;
        fp = 1'b0;
        forever begin
            @(negedge clk);
            if (arst) begin
                last_good = 8'h00;
            end else begin
                if (rx_done) begin
                    done_cyc = cyc;
                    chk("done_width", 32'(dp), 32'd0);
                    chk("done_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("done_kind", 32'(e.err), 32'd0);
                        chk("data_out", 32'(data_out), 32'(e.data));
                        last_good = e.data;
                    end
                end
                if (frame_err) begin
                    chk("ferr_width", 32'(fp), 32'd0);
                    chk("ferr_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("ferr_kind", 32'(e.err), 32'd1);
                    end
                    chk("ferr_data_hold", 32'(data_out), 32'(last_good));
                end
            end
            dp = rx_done;
            fp = frame_err;
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_tick;
        logic rose;
        int   k;

        // Reset
        repeat (3) @(negedge clk);
        any_tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any_tick = any_tick | dut.tick;
        end
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_done", 32'(rx_done), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_tick", 32'(any_tick), 32'd0);
        arst = 1'b0;
        repeat (5) @(negedge clk);

        // Divisor table: tick spacing per baud_sel, then a false start
        for (int s = 0; s < 16; s++) begin
            int d;
            int gap;
            d = exp_div(s);
            baud_sel = 4'(s);
            @(negedge clk);
            rx = 1'b0;
            k = 0;
            while (!dut.tick && k < 2 * d + 10) begin
                @(negedge clk);
                k++;
            end
            @(negedge clk);
            gap = 1;
            while (!dut.tick && gap < 2 * d + 10) begin
                @(negedge clk);
                gap++;
            end
            chk($sformatf("tick_gap_sel%0d", s), 32'(gap), 32'(d));
            rx = 1'b1;
            k = 0;
            while (rx_busy && k < 9 * d + 10) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("sweep_idle_sel%0d", s), 32'(rx_busy), 32'd0);
        end

        // Nominal byte at 9600 with 100 us bits -> 0xED
        baud_sel = 4'd3;
        repeat (20) @(negedge clk);
        sb.push_back('{err: 1'b0, data: 8'hED});
        drive(1'b0, 1000);
        drive(1'b1, 1000);
        drive(1'b0, 1000);
        drive(1'b1, 1000);
        drive(1'b1, 1000);
        drive(1'b0, 1000);
        drive(1'b1, 1000);
        rx = 1'b1;
        drain("nominal", 20000);
        chk("nominal_data", 32'(data_out), 32'hED);

        // False start: 2 us low pulse
        @(negedge clk);
        rose = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rose = rose | rx_busy;
        end
        rx = 1'b1;
        k = 0;
        while (rx_busy && k < 8 * exp_div(3) + 10) begin
            @(negedge clk);
            k++;
        end
        chk("fs_rise", 32'(rose), 32'd1);
        chk("fs_fall", 32'(rx_busy), 32'd0);
        chk("fs_data", 32'(data_out), 32'hED);

        // Exact timing at sel 7
        baud_sel = 4'd7;
        repeat (10) @(negedge clk);
        send(8'h55, 1'b1, 16 * exp_div(7));
        drain("exact", 4000);
        chk("exact_latency", 32'(done_cyc - fall_cyc),
            32'(152 * exp_div(7) + 3));
        chk("exact_data", 32'(data_out), 32'h55);

        // Framing error
        repeat (10) @(negedge clk);
        send(8'hA3, 1'b0, 16 * exp_div(7));
        drain("ferr", 4000);
        chk("ferr_keep", 32'(data_out), 32'h55);

        // Back-to-back frames
        repeat (10) @(negedge clk);
        send(8'h12, 1'b1, 16 * exp_div(7));
        send(8'h34, 1'b1, 16 * exp_div(7));
        drain("b2b", 4000);
        chk("b2b_data", 32'(data_out), 32'h34);

        // Reset mid-data
        repeat (10) @(negedge clk);
        drive(1'b0, 80);
        drive(1'b1, 80);
        drive(1'b0, 80);
        drive(1'b1, 40);
        chk("mid_busy", 32'(rx_busy), 32'd1);
        arst = 1'b1;
        #1;
        chk("mid_rst_data", 32'(data_out), 32'h00);
        chk("mid_rst_busy", 32'(rx_busy), 32'd0);
        chk("mid_rst_done", 32'(rx_done), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        arst = 1'b0;
        repeat (20 * 80) @(negedge clk);
        drain("post_rst", 100);
        chk("post_rst_data", 32'(data_out), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
